// File: rtl/mmio_fifo_port_if.sv
// Purpose: CPU data-memory bus plus TX/RX stream handshakes for mmio_fifo_port.
// Latency: none (wiring only).
// Backpressure: tx_ready throttles the TX stream; rx_ready advertises RX space.
// Ports: master = CPU/stream environment side, slave = the device.
interface mmio_fifo_port_if;
    logic [15:0] read_address;
    logic        read_enable;
    logic [15:0] write_address;
    logic        write_enable;
    logic [15:0] data_in;
    logic [15:0] data_out;
    logic        selected;
    logic [15:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [15:0] rx_data;
    logic        rx_valid;
    logic        rx_ready;

    modport slave (
        input  read_address, read_enable, write_address, write_enable, data_in,
               tx_ready, rx_data, rx_valid,
        output data_out, selected, tx_data, tx_valid, rx_ready
    );

    modport master (
        output read_address, read_enable, write_address, write_enable, data_in,
               tx_ready, rx_data, rx_valid,
        input  data_out, selected, tx_data, tx_valid, rx_ready
    );
endinterface

// File: rtl/mmio_fifo_port.sv
// Purpose: 4-word memory-mapped window bridging CPU accesses to a TX FIFO and an RX FIFO.
// Latency: data_out/selected registered, 1 cycle after read_address; FIFO state updates on the edge.
// Backpressure: TX pushes into a full FIFO drop (sticky flag); RX accepts only when not full.
// Ports: clock, reset (async active-low), bus (mmio_fifo_port_if.slave).
//   Offsets: +0 STATUS(r)/CONTROL(w), +1 TX_DATA(w), +2 RX_DATA(r, pops on read_enable), +3 COUNTS(r).
module mmio_fifo_port #(
    parameter logic [15:0] BASE_ADDRESS = 16'h2000,
    parameter int          DEPTH_LOG2   = 3
) (
    input  logic              clock,
    input  logic              reset,
    mmio_fifo_port_if.slave   bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;

    typedef logic [DEPTH_LOG2-1:0] ptr_t;
    typedef logic [CW-1:0]         cnt_t;

    localparam cnt_t FULL_CNT = cnt_t'(DEPTH);

    logic [15:0] tx_mem [DEPTH];
    logic [15:0] rx_mem [DEPTH];
    ptr_t        tx_wr_ptr, tx_rd_ptr, rx_wr_ptr, rx_rd_ptr;
    cnt_t        tx_count, rx_count;
    logic        tx_drop, rx_underflow;
    logic [15:0] data_out_q;
    logic        selected_q;

    // Address decode: window is the 4-word aligned block at BASE_ADDRESS.
    logic       rd_hit, wr_hit;
    logic [1:0] rd_off, wr_off;
    assign rd_hit = bus.read_address[15:2]  == BASE_ADDRESS[15:2];
    assign wr_hit = bus.write_address[15:2] == BASE_ADDRESS[15:2];
    assign rd_off = bus.read_address[1:0];
    assign wr_off = bus.write_address[1:0];

    logic tx_full, tx_empty, rx_full, rx_empty;
    assign tx_full  = tx_count == FULL_CNT;
    assign tx_empty = tx_count == '0;
    assign rx_full  = rx_count == FULL_CNT;
    assign rx_empty = rx_count == '0;

    logic ctrl_wr, tx_flush, sticky_clr;
    logic tx_pop, tx_push_req, tx_push, tx_drop_set;
    logic rx_pop_req, rx_pop, rx_underflow_set, rx_push;

    assign ctrl_wr     = bus.write_enable && wr_hit && (wr_off == 2'd0);
    assign tx_flush    = ctrl_wr && bus.data_in[0];
    assign sticky_clr  = ctrl_wr && bus.data_in[4];

    // A push into a full TX FIFO still fits when the sink drains a word on
    // the same edge. Flush overrides the push entirely (no drop reported).
    assign tx_pop      = !tx_empty && bus.tx_ready;
    assign tx_push_req = bus.write_enable && wr_hit && (wr_off == 2'd1);
    assign tx_push     = tx_push_req && !tx_flush && (!tx_full || tx_pop);
    assign tx_drop_set = tx_push_req && !tx_flush && tx_full && !tx_pop;

    assign rx_pop_req       = bus.read_enable && rd_hit && (rd_off == 2'd2);
    assign rx_pop           = rx_pop_req && !rx_empty;
    assign rx_underflow_set = rx_pop_req && rx_empty;
    // rx_ready comes from the pre-edge count, so a full FIFO never accepts
    // even when the CPU pops on the same edge.
    assign rx_push          = bus.rx_valid && !rx_full;

    // Read mux over pre-edge state.
    logic [15:0] rd_word;
    always_comb begin
        rd_word = 16'h0000;
        if (rd_hit) begin
            case (rd_off)
                2'd0:    rd_word = {10'b0, rx_underflow, tx_drop, rx_full, !rx_empty,
                                    tx_empty, tx_full};
                2'd2:    rd_word = rx_empty ? 16'h0000 : rx_mem[rx_rd_ptr];
                2'd3:    rd_word = {8'(rx_count), 8'(tx_count)};
                default: rd_word = 16'h0000;
            endcase
        end
    end

    // Storage arrays carry no reset; validity is tracked by the counts.
    always_ff @(posedge clock) begin
        if (tx_push) tx_mem[tx_wr_ptr] <= bus.data_in;
        if (rx_push) rx_mem[rx_wr_ptr] <= bus.rx_data;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tx_wr_ptr    <= '0;
            tx_rd_ptr    <= '0;
            tx_count     <= '0;
            rx_wr_ptr    <= '0;
            rx_rd_ptr    <= '0;
            rx_count     <= '0;
            tx_drop      <= 1'b0;
            rx_underflow <= 1'b0;
            data_out_q   <= 16'h0000;
            selected_q   <= 1'b0;
        end else begin
            data_out_q <= rd_word;
            selected_q <= rd_hit;

            if (tx_flush) begin
                tx_wr_ptr <= '0;
                tx_rd_ptr <= '0;
                tx_count  <= '0;
            end else begin
                if (tx_push) tx_wr_ptr <= tx_wr_ptr + ptr_t'(1);
                if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + ptr_t'(1);
                case ({tx_push, tx_pop})
                    2'b10:   tx_count <= tx_count + cnt_t'(1);
                    2'b01:   tx_count <= tx_count - cnt_t'(1);
                    default: tx_count <= tx_count;
                endcase
            end

            if (rx_push) rx_wr_ptr <= rx_wr_ptr + ptr_t'(1);
            if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + ptr_t'(1);
            case ({rx_push, rx_pop})
                2'b10:   rx_count <= rx_count + cnt_t'(1);
                2'b01:   rx_count <= rx_count - cnt_t'(1);
                default: rx_count <= rx_count;
            endcase

            // Set beats clear when both happen on the same edge.
            if (tx_drop_set)      tx_drop <= 1'b1;
            else if (sticky_clr)  tx_drop <= 1'b0;
            if (rx_underflow_set) rx_underflow <= 1'b1;
            else if (sticky_clr)  rx_underflow <= 1'b0;
        end
    end

    assign bus.data_out = data_out_q;
    assign bus.selected = selected_q;
    assign bus.tx_data  = tx_mem[tx_rd_ptr];
    assign bus.tx_valid = !tx_empty;
    assign bus.rx_ready = !rx_full;
endmodule
